// File: rtl/mdu_pkg.sv
// mdu_pkg: shared operation encodings, FSM states and iteration count for the MDU.
package mdu_pkg;
   localparam int unsigned XLEN = 32;
   localparam int unsigned ITER = 32;
   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_MULT  = 2'b01,
      OP_DIVU  = 2'b10,
      OP_DIV   = 2'b11
   } op_e;
   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_FIX  = 2'b10
   } state_e;
endpackage

// File: rtl/mdu_if.sv
// mdu_if: request/result bundle between the issuing side and the MDU.
interface mdu_if;
   import mdu_pkg::*;
   logic [XLEN-1:0] a, b, wdata, hi, lo;
   op_e op;
   logic start, hi_we, lo_we, busy, done;
   modport master (output a, b, op, start, hi_we, lo_we, wdata, input hi, lo, busy, done);
   modport slave (input a, b, op, start, hi_we, lo_we, wdata, output hi, lo, busy, done);
endinterface

// File: rtl/mdu.sv
// mdu: iterative 32-bit multiply/divide unit with HI/LO result registers.
module mdu
   import mdu_pkg::*;
(
   input logic  clk,
   input logic  reset_n,
   mdu_if.slave bus
);
   state_e state_q;
   op_e op_q;
   logic [4:0] cnt_q;
   logic [63:0] work_q, work_d, prod;
   logic [31:0] opnd_q, hi_q, lo_q, hi_fix, lo_fix, mag_a, mag_b, qv, rv;
   logic negq_q, negr_q, done_q;
   logic sa, sb, is_div, ge, div0;
   logic [32:0] add_x, add_y, sum;
   assign sa = bus.op[0] & bus.a[31];
   assign sb = bus.op[0] & bus.b[31];
   assign mag_a = sa ? -bus.a : bus.a;
   assign mag_b = sb ? -bus.b : bus.b;
   // Division subtracts from the shifted partial remainder; work_q[63] is its carry-out bit,
   // which guarantees the remainder exceeds any 32-bit divisor.
   always_comb begin
      is_div = op_q[1];
      add_x = is_div ? {1'b0, work_q[62:31]} : {1'b0, work_q[63:32]};
      add_y = is_div ? ~{1'b0, opnd_q} : (work_q[0] ? {1'b0, opnd_q} : 33'd0);
      sum = add_x + add_y + {32'd0, is_div};
      ge = work_q[63] | ~sum[32];
      work_d = !is_div ? {sum, work_q[31:1]} :
               ge ? {sum[31:0], work_q[30:0], 1'b1} : {work_q[62:0], 1'b0};
      prod = negq_q ? -work_q : work_q;
      qv = work_q[31:0];
      rv = work_q[63:32];
      div0 = opnd_q == 32'd0;
      lo_fix = !is_div ? prod[31:0] : div0 ? 32'hFFFF_FFFF : negq_q ? -qv : qv;
      hi_fix = !is_div ? prod[63:32] : negr_q ? -rv : rv;
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         op_q <= OP_MULTU;
         cnt_q <= '0;
         work_q <= '0;
         opnd_q <= '0;
         hi_q <= '0;
         lo_q <= '0;
         negq_q <= 1'b0;
         negr_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  op_q <= bus.op;
                  work_q <= {32'd0, mag_a};
                  opnd_q <= mag_b;
                  negq_q <= sa ^ sb;
                  negr_q <= sa;
                  cnt_q <= '0;
                  state_q <= S_RUN;
               end else begin
                  if (bus.hi_we) hi_q <= bus.wdata;
                  if (bus.lo_we) lo_q <= bus.wdata;
               end
            end
            S_RUN: begin
               work_q <= work_d;
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'(ITER - 1)) state_q <= S_FIX;
            end
            S_FIX: begin
               hi_q <= hi_fix;
               lo_q <= lo_fix;
               done_q <= 1'b1;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
   assign bus.hi = hi_q;
   assign bus.lo = lo_q;
   assign bus.busy = state_q != S_IDLE;
   assign bus.done = done_q;
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed vector table plus hand-written sequences for the MDU.
module tb_mdu;
   import mdu_pkg::*;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int tests = 0;
   int fails = 0;
   mdu_if bus();
   mdu dut (.clk(clk), .reset_n(reset_n), .bus(bus));
   always #5 clk = ~clk;
   typedef struct {
      op_e op;
      logic [31:0] a, b, hi, lo;
   } vec_t;
   vec_t v[14];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   // Drives start during cycle 0; returns at the cycle-1 sample point.
   task automatic launch(input op_e o, input logic [31:0] x, input logic [31:0] y);
      bus.op = o;
      bus.a = x;
      bus.b = y;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask
   task automatic wait_done(input int from, output int cyc, output int nb);
      nb = 0;
      for (cyc = from; cyc < 100; cyc++) begin
         if (bus.busy) nb++;
         if (bus.done) break;
         @(negedge clk);
      end
   endtask
   initial begin
      int cyc, nb, dn;
      v[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      v[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
      v[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      v[3]  = '{OP_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
      v[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      v[5]  = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
      v[6]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      v[7]  = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
      v[8]  = '{OP_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
      v[9]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      v[10] = '{OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
      v[11] = '{OP_DIV,   32'hFFFFFF00, 32'h00000000, 32'hFFFFFF00, 32'hFFFFFFFF};
      v[12] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
      v[13] = '{OP_DIVU,  32'h00000005, 32'hFFFFFFFF, 32'h00000005, 32'h00000000};
      bus.op = OP_MULTU;
      bus.a = '0;
      bus.b = '0;
      bus.start = 1'b0;
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      bus.wdata = '0;
      repeat (3) @(negedge clk);
      chk("reset hi", bus.hi, 32'h0);
      chk("reset lo", bus.lo, 32'h0);
      chk("reset busy", {31'd0, bus.busy}, 32'h0);
      chk("reset done", {31'd0, bus.done}, 32'h0);
      reset_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 14; i++) begin
         launch(v[i].op, v[i].a, v[i].b);
         wait_done(1, cyc, nb);
         chk($sformatf("v%0d done cycle", i), cyc, 34);
         chk($sformatf("v%0d busy cycles", i), nb, 33);
         chk($sformatf("v%0d hi", i), bus.hi, v[i].hi);
         chk($sformatf("v%0d lo", i), bus.lo, v[i].lo);
      end
      // start re-pulsed at cycle 5 must be ignored
      @(negedge clk);
      launch(OP_MULTU, 32'd3, 32'd5);
      repeat (4) @(negedge clk);
      bus.op = OP_DIVU;
      bus.a = 32'd7;
      bus.b = 32'd9;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(6, cyc, nb);
      chk("ignore start cycle", cyc, 34);
      chk("ignore start hi", bus.hi, 32'd0);
      chk("ignore start lo", bus.lo, 32'd15);
      // back-to-back start on the done cycle
      @(negedge clk);
      launch(OP_MULTU, 32'd2, 32'd3);
      wait_done(1, cyc, nb);
      chk("b2b first cycle", cyc, 34);
      chk("b2b first lo", bus.lo, 32'd6);
      launch(OP_DIVU, 32'd100, 32'd7);
      wait_done(35, cyc, nb);
      chk("b2b second cycle", cyc, 68);
      chk("b2b second hi", bus.hi, 32'd2);
      chk("b2b second lo", bus.lo, 32'd14);
      // reset in cycle 10 of a MULT
      @(negedge clk);
      launch(OP_MULT, 32'hFFFFFFFD, 32'd7);
      repeat (9) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      chk("midrst busy", {31'd0, bus.busy}, 32'h0);
      chk("midrst hi", bus.hi, 32'h0);
      chk("midrst lo", bus.lo, 32'h0);
      dn = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done) dn++;
      end
      chk("midrst no done", dn, 0);
      // MTHI/MTLO in IDLE, ignored with start and during RUN
      bus.hi_we = 1'b1;
      bus.wdata = 32'h12345678;
      @(negedge clk);
      bus.hi_we = 1'b0;
      chk("mthi hi", bus.hi, 32'h12345678);
      chk("mthi lo", bus.lo, 32'h0);
      chk("mthi done", {31'd0, bus.done}, 32'h0);
      bus.lo_we = 1'b1;
      bus.wdata = 32'h0BADF00D;
      @(negedge clk);
      bus.lo_we = 1'b0;
      chk("mtlo lo", bus.lo, 32'h0BADF00D);
      bus.hi_we = 1'b1;
      bus.wdata = 32'hFFFFFFFF;
      launch(OP_MULTU, 32'd4, 32'd5);
      bus.hi_we = 1'b0;
      chk("mthi on start hi", bus.hi, 32'h12345678);
      chk("mthi on start busy", {31'd0, bus.busy}, 32'h1);
      repeat (2) @(negedge clk);
      bus.lo_we = 1'b1;
      bus.wdata = 32'hDEADBEEF;
      @(negedge clk);
      bus.lo_we = 1'b0;
      chk("mtlo in run lo", bus.lo, 32'h0BADF00D);
      repeat (29) @(negedge clk);
      chk("hold c33 hi", bus.hi, 32'h12345678);
      chk("hold c33 lo", bus.lo, 32'h0BADF00D);
      chk("hold c33 busy", {31'd0, bus.busy}, 32'h1);
      @(negedge clk);
      chk("c34 done", {31'd0, bus.done}, 32'h1);
      chk("c34 hi", bus.hi, 32'h0);
      chk("c34 lo", bus.lo, 32'd20);
      @(negedge clk);
      chk("done one cycle", {31'd0, bus.done}, 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter: none; width fixed at 32 bits, iteration count 32 from the shared package.
REQ-002 clk  input  1  rising-edge clock; sole clock.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 a  input  32  operand A: multiplicand or dividend.
REQ-005 b  input  32  operand B: multiplier or divisor.
REQ-006 op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-007 start  input  1  launch request; sampled with a, b, op.
REQ-008 hi_we  input  1  MTHI write enable.
REQ-009 lo_we  input  1  MTLO write enable.
REQ-010 wdata  input  32  data for MTHI/MTLO.
REQ-011 hi  output  32  HI register: product upper word or remainder.
REQ-012 lo  output  32  LO register: product lower word or quotient.
REQ-013 busy  output  1  high while an operation is in flight.
REQ-014 done  output  1  one-cycle pulse when hi/lo take a new result.

Function
REQ-015 FSM states: IDLE, RUN, FIX; busy SHALL equal (state != IDLE).
REQ-016 IDLE with start=1 at an edge: latch a, b, op; clear iteration counter; go to RUN.
REQ-017 start while busy SHALL be ignored; no queuing.
REQ-018 RUN: exactly 32 edges (one iteration per edge; counter 0..31), then FIX.
REQ-019 FIX: one edge; apply sign correction; write hi/lo; go to IDLE; done=1 during the following cycle only.
REQ-020 Latency: start presented in cycle 0; busy high cycles 1-33; done high and new hi/lo visible in cycle 34.
REQ-021 start in the cycle where done=1 (state IDLE) SHALL be accepted.
REQ-022 Multiply: radix-2 shift-add on magnitudes; {hi,lo} = 64-bit product.
REQ-023 MULT: the product SHALL be negated when sign(a) xor sign(b).
REQ-024 Divide: restoring division on magnitudes; lo = quotient, hi = remainder.
REQ-025 DIV: quotient negative iff sign(a) xor sign(b); remainder sign follows dividend; truncation toward zero.
REQ-026 Divide by zero (DIVU and DIV): lo = 0xFFFFFFFF, hi = a (unmodified dividend).
REQ-027 DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0x00000000.
REQ-028 hi_we/lo_we in IDLE: wdata written to hi/lo at that edge; done not asserted.
REQ-029 hi_we/lo_we while busy, or in the cycle start is accepted: SHALL be ignored.
REQ-030 hi/lo SHALL hold their previous values during RUN/FIX until the FIX edge.

Reset
REQ-031 reset_n=0 at an edge: state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, operand latches=0.
REQ-032 Reset has priority over start, hi_we, lo_we.
REQ-033 Reset mid-operation: the operation is abandoned; no done pulse; no partial result reaches hi/lo.

Structure
REQ-034 Shared package mdu_pkg SHALL hold: op encodings, FSM state enum, ITER=32 constant.
REQ-035 Single module; no sub-module is natural. Magnitude and negate logic stays inline, shared by multiply and divide paths.
REQ-036 One 64-bit working register plus a 32-bit operand register; one 33-bit adder/subtractor shared across ops.

Verification
REQ-037 MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done in cycle 34; busy cycles 1-33.
REQ-038 MULT 0xFFFFFFFD(-3)*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV 0xFFFFFFF9(-7)/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-039 DIVU 100/0 -> lo=0xFFFFFFFF, hi=0x00000064; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-040 start re-pulsed at cycle 5 with different operands -> ignored; result matches the first op. Back-to-back start on the done cycle -> second result in cycle 68.
REQ-041 reset_n=0 in cycle 10 of a MULT -> busy=0, hi=lo=0 next cycle; no done within 40 cycles.
REQ-042 IDLE: hi_we with wdata=0x12345678 -> hi=0x12345678, lo unchanged. lo_we during RUN -> lo unchanged.
